// File: rtl/ahb_write_scheduler.sv
`default_nettype none
// ============================================================================
// ahb_write_scheduler : issues each 128-bit cipher block as one AHB-Lite INCR4
//                       word write burst into a rolling destination window
// Revision 1.0
// ============================================================================
module ahb_write_scheduler #(
    parameter int AHB_BUS_SIZE = 32,
    parameter int WINDOW_BYTES = 256,
    parameter int CNT_W        = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [AHB_BUS_SIZE-1:0] destination,
    input  logic                    dest_updated,
    input  logic [127:0]            encr_text,
    input  logic                    text_valid,
    output logic                    text_ready,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic [AHB_BUS_SIZE-1:0] HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [1:0]              HTRANS,
    output logic [AHB_BUS_SIZE-1:0] HWDATA,
    output logic                    busy,
    output logic                    blk_done,
    output logic                    bus_err,
    output logic [CNT_W-1:0]        blocks_written
);

    localparam int OFF_W = $clog2(WINDOW_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_LAST = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              beat_q, beat_d;
    logic [AHB_BUS_SIZE-1:0] base_q, base_d;
    logic [OFF_W-1:0]        offset_q, offset_d;
    logic [AHB_BUS_SIZE-1:0] addr_q, addr_d;
    logic [127:0]            block_q, block_d;
    logic [AHB_BUS_SIZE-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    blk_done_q, blk_done_d;
    logic                    bus_err_q, bus_err_d;

    // word0 sits in the top 32 bits, so word n is w_words[3-n]
    logic [3:0][31:0]        w_words;
    logic [1:0]              w_prev;

    assign w_words = block_q;
    assign w_prev  = beat_q - 2'd1;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        offset_d   = offset_q;
        addr_d     = addr_q;
        block_d    = block_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        blk_done_d = 1'b0;
        bus_err_d  = 1'b0;

        text_ready = 1'b0;
        HADDR      = '0;
        HWRITE     = 1'b0;
        HSIZE      = 3'b000;
        HBURST     = 3'b000;
        HTRANS     = 2'b00;
        HWDATA     = '0;

        if (state_q != S_IDLE && dest_updated) begin
            shadow_d  = destination;
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                text_ready = !HRESET && !dest_updated && !pending_q;
                if (dest_updated || pending_q) begin
                    base_d    = dest_updated ? destination : shadow_q;
                    offset_d  = '0;
                    pending_d = 1'b0;
                end else if (text_valid && text_ready) begin
                    block_d = encr_text;
                    addr_d  = base_q + AHB_BUS_SIZE'(offset_q);
                    beat_d  = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                HADDR  = addr_q + AHB_BUS_SIZE'({beat_q, 2'b00});
                HWRITE = 1'b1;
                HSIZE  = 3'b010;
                HBURST = 3'b011;
                HTRANS = (beat_q == 2'd0) ? 2'b10 : 2'b11;
                if (beat_q != 2'd0) begin
                    HWDATA = AHB_BUS_SIZE'(w_words[2'd3 - w_prev]);
                end
                // beat 0 has no data phase yet, so an error cannot apply there
                if (beat_q != 2'd0 && HRESP && !HREADY) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    if (beat_q == 2'd3) begin
                        state_d = S_LAST;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            S_LAST: begin
                HWDATA = AHB_BUS_SIZE'(w_words[0]);
                if (HRESP && !HREADY) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    state_d    = S_IDLE;
                    offset_d   = offset_q + OFF_W'(16);
                    cnt_d      = cnt_q + CNT_W'(1);
                    blk_done_d = 1'b1;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            beat_q     <= 2'd0;
            base_q     <= '0;
            offset_q   <= '0;
            addr_q     <= '0;
            block_q    <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            blk_done_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            offset_q   <= offset_d;
            addr_q     <= addr_d;
            block_q    <= block_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            blk_done_q <= blk_done_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign blk_done       = blk_done_q;
    assign bus_err        = bus_err_q;
    assign blocks_written = cnt_q;

endmodule
`default_nettype wire

// File: doc/ahb_write_scheduler.md
Name: ahb_write_scheduler

Overview:
- Sequences the AHB-Lite master port for the encryption output path.
- Arbitrates between two requesters:
  - destination-address updates from the config side;
  - 128-bit encrypted-text blocks from the cipher core.
- Each accepted block is issued as one 4-beat INCR4 word write burst to a rolling address window starting at the latest destination.
- Handles AHB pipelining, HREADY wait states and HRESP error aborts.

Parameters:
- AHB_BUS_SIZE, 32, AHB address/data width.
- WINDOW_BYTES, 256, size of the destination window; power of two, multiple of 16.
- CNT_W, 16, width of blocks_written counter.

Ports:
- HCLK  input  1  system clock, all logic on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- destination  input  AHB_BUS_SIZE  new window base address.
- dest_updated  input  1  one-cycle pulse: load destination.
- encr_text  input  128  block to write; word0 = [127:96] … word3 = [31:0].
- text_valid  input  1  block request from cipher core.
- text_ready  output  1  scheduler accepts block this cycle.
- HREADY  input  1  AHB transfer-complete.
- HRESP  input  1  AHB error response.
- HADDR  output  AHB_BUS_SIZE  address phase.
- HWRITE  output  1  write indicator.
- HSIZE  output  3  transfer size.
- HBURST  output  3  burst type.
- HTRANS  output  2  transfer type.
- HWDATA  output  AHB_BUS_SIZE  write data (data phase).
- busy  output  1  burst in progress.
- blk_done  output  1  one-cycle pulse: block fully written.
- bus_err  output  1  one-cycle pulse: burst aborted by HRESP.
- blocks_written  output  CNT_W  count of completed blocks; wraps at 2^CNT_W.

Behaviour:
- Reset values:
  - HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HTRANS=IDLE(00), HWDATA=0.
  - text_ready=0, busy=0, blk_done=0, bus_err=0, blocks_written=0.
  - base=0, offset=0, dest_pending=0, block register=0.
- Reset is sampled on HCLK; asserting it mid-burst forces reset values on the next edge. No completion pulse is generated for the aborted burst.
- States: IDLE, ADDR (beats 0-3 address phase), LAST (final data phase), ERR.
- IDLE:
  - text_ready = !dest_updated && !dest_pending.
  - dest_updated or dest_pending: base<=destination (latched copy if pending), offset<=0, clear pending. Text is not accepted in that cycle.
  - text_valid && text_ready: latch encr_text, A = base + offset (mod 2^32), go to ADDR with beat=0.
- dest_updated outside IDLE: latch destination into a shadow register and set dest_pending; applied on return to IDLE. A later pulse overwrites the shadow.
- ADDR, beat n:
  - Drives HADDR = A + 4n, HWRITE=1, HSIZE=010, HBURST=011.
  - HTRANS = NONSEQ(10) for n=0, SEQ(11) otherwise.
  - HWDATA = word(n-1) for n>0.
  - Advances only when HREADY=1; after beat 3, go to LAST.
- LAST:
  - HTRANS=IDLE, HWRITE=0, HBURST=0, HWDATA=word3.
  - On HREADY=1: go to IDLE; offset <= (offset+16) mod WINDOW_BYTES; blocks_written++; blk_done=1 in the following cycle.
- HREADY=0 holds every bus output stable (address and data).
- Zero-wait latency: acceptance at cycle T; NONSEQ at T+1; beats at T+2, T+3, T+4; LAST at T+5; blk_done at T+6; text_ready high again at T+6.
- Error handling:
  - HRESP=1 with HREADY=0 (first error cycle) in any data phase → ERR.
  - ERR drives HTRANS=IDLE, HWRITE=0 and cancels remaining beats.
  - On HREADY=1: go to IDLE and pulse bus_err for one cycle. Block is dropped; offset and count are unchanged.
- busy = (state != IDLE).

Test Plan:
- Reset: HRESET=1 for 2 cycles → HADDR=0, HWRITE=0, HTRANS=00, text_ready=0 during reset and 1 the cycle after release.
- Basic burst: dest_updated with destination=0x4, then text_valid with encr_text=0x2A472D4B_6150645_367566B5_970337336 form (words 0x2A472D4B, 0x61506453, 0x67566B59, 0x70337336):
  - HADDR 0x4, 0x8, 0xC, 0x10 with HTRANS 10, 11, 11, 11;
  - HWDATA words in order one cycle later;
  - blk_done at T+6; blocks_written=1.
- Back-to-back: 17 blocks with destination=0x40 and WINDOW_BYTES=256 → block k starts at 0x40+16·(k mod 16); block 16 wraps to 0x40; blocks_written=17.
- Wait states: HREADY=0 for 3 cycles during beat 2 → HADDR=A+8 and HWDATA=word1 held stable; blk_done delayed by exactly 3 cycles.
- Error abort: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 during beat-1 data phase → HTRANS=00 next cycle, bus_err pulse, no blk_done, next block reuses the same address.
- Mid-burst destination and reset:
  - dest_updated (destination=0x100) during beat 1 → current burst completes at the old address, next burst starts at 0x100.
  - HRESET during beat 2 → all outputs return to reset values on the next edge.
